// File: rtl/accel_avg_pkg.sv
// Shared types and helpers for the accelerometer moving-average datapath.
// Holds the sample type, the 16-bit saturator and the reciprocal constant function.
package accel_avg_pkg;

    localparam int SAMPLE_W = 16;
    localparam int RECIP_W  = 18;
    localparam int SAT_IN_W = 64;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam logic signed [SAT_IN_W-1:0] SAT_HI     = 64'sd32767;
    localparam logic signed [SAT_IN_W-1:0] SAT_LO     = -64'sd32768;
    localparam sample_t                    SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t                    SAMPLE_MIN = 16'sh8000;

    function automatic sample_t sat16(input logic signed [SAT_IN_W-1:0] v);
        if (v > SAT_HI) begin
            return SAMPLE_MAX;
        end
        if (v < SAT_LO) begin
            return SAMPLE_MIN;
        end
        return $signed(v[SAMPLE_W-1:0]);
    endfunction

    // round(2^sh / window), evaluated at elaboration time
    function automatic int recip(input int window, input int sh);
        longint num;
        num = (longint'(1) << sh) + longint'(window / 2);
        return int'(num / longint'(window));
    endfunction

endpackage

// File: rtl/avg_sample_ram.sv
// Simple dual-port sample buffer with a registered read port (maps to block RAM).
// Contents are never cleared; the caller gates stale reads.
module avg_sample_ram
    import accel_avg_pkg::*;
#(
    parameter int DEPTH  = 1000,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  sample_t           wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output sample_t           rd_data_o
);

    sample_t mem [0:DEPTH-1];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem[rd_addr_i];
    end

endmodule

// File: rtl/accel_moving_avg.sv
// Boxcar moving average of one accelerometer axis over the last WINDOW FIR samples.
// Pipeline: running-sum update, reciprocal multiply, round and saturate (3-cycle latency).
module accel_moving_avg
    import accel_avg_pkg::*;
#(
    parameter int WINDOW   = 1000,
    parameter int RECIP_SH = 26,
    parameter int RECIP    = recip(WINDOW, RECIP_SH)
) (
    input  logic    sys_clk,
    input  logic    reset,
    input  logic    clear,
    input  logic    in_valid,
    input  sample_t in_data,
    output logic    out_valid,
    output sample_t out_data,
    output logic    out_primed
);

    localparam int PTR_W  = $clog2(WINDOW);
    localparam int FILL_W = $clog2(WINDOW + 1);
    localparam int SUM_W  = SAMPLE_W + $clog2(WINDOW);
    localparam int PROD_W = SUM_W + RECIP_W;

    localparam logic [PTR_W-1:0]         LAST_PTR  = PTR_W'(WINDOW - 1);
    localparam logic [FILL_W-1:0]        FULL_CNT  = FILL_W'(WINDOW);
    localparam logic signed [PROD_W-1:0] RECIP_EXT = PROD_W'(RECIP);
    localparam logic signed [PROD_W-1:0] RND_BIAS  = PROD_W'(1) <<< (RECIP_SH - 1);

    function automatic logic signed [SAT_IN_W-1:0] round_shift(
        input logic signed [PROD_W-1:0] p
    );
        logic signed [PROD_W-1:0] biased;
        biased = p + RND_BIAS;
        return SAT_IN_W'(biased >>> RECIP_SH);
    endfunction

    logic                     flush;
    logic                     accept;
    logic                     full_now;
    logic                     full_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic signed [SUM_W-1:0]  in_ext, old_ext;
    sample_t                  ram_rd;

    logic                     vld_p1_q, vld_p2_q;
    logic                     full_p1_q, full_p2_q;
    logic signed [PROD_W-1:0] prod_p2_q;
    logic                     out_valid_q;
    logic                     out_primed_q;
    sample_t                  out_data_q;

    assign flush    = reset | clear;
    assign accept   = in_valid & ~flush;
    assign full_now = (fill_q == FULL_CNT);
    assign full_d   = (fill_d == FULL_CNT);

    // The read port is always aimed at the next write slot, so the sample
    // about to be evicted is already on ram_rd when in_valid arrives.
    avg_sample_ram #(
        .DEPTH  (WINDOW),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk_i     (sys_clk),
        .wr_en_i   (accept),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data),
        .rd_addr_i (wr_ptr_d),
        .rd_data_o (ram_rd)
    );

    assign in_ext  = SUM_W'(in_data);
    assign old_ext = full_now ? SUM_W'(ram_rd) : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        sum_d    = sum_q;
        if (flush) begin
            wr_ptr_d = '0;
            fill_d   = '0;
            sum_d    = '0;
        end else if (in_valid) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            fill_d   = full_now ? fill_q : fill_q + FILL_W'(1);
            sum_d    = sum_q + in_ext - old_ext;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (flush) begin
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            sum_q        <= '0;
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_primed_q <= 1'b0;
        end else begin
            // p0 -> p1: window bookkeeping and running sum
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            sum_q    <= sum_d;
            vld_p1_q <= in_valid;
            // p1 -> p2: reciprocal multiply
            vld_p2_q <= vld_p1_q;
            // p2 -> out: round, saturate, export
            out_valid_q <= vld_p2_q;
            if (vld_p2_q) begin
                out_data_q   <= sat16(round_shift(prod_p2_q));
                out_primed_q <= out_primed_q | full_p2_q;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        full_p1_q <= full_d;
        full_p2_q <= full_p1_q;
        prod_p2_q <= PROD_W'(sum_q) * RECIP_EXT;
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_primed = out_primed_q;

endmodule

// File: tb/tb_accel_moving_avg.sv
// Scoreboard bench for accel_moving_avg: stimulus pushes expected outputs,
// a negedge monitor pops and compares data, primed flag and latency.
module tb_accel_moving_avg;

    localparam int     NOHAND  = -100000;
    localparam int     WIN     = 1000;
    localparam longint RECIP_C = 67109;

    typedef struct {
        int val;
        bit primed;
        int cyc;
    } exp_t;

    logic               sys_clk  = 1'b0;
    logic               reset    = 1'b1;
    logic               clear    = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_data  = '0;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic               out_primed;

    int     cyc      = 0;
    int     checks   = 0;
    int     failures = 0;
    exp_t   sb[$];
    exp_t   mon_e;
    int     win[$];
    longint msum = 0;

    accel_moving_avg dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_primed (out_primed)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int spec_avg(input longint s);
        longint r;
        r = (s * RECIP_C + (longint'(1) << 25)) >>> 26;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    function automatic void model_flush();
        win.delete();
        msum = 0;
    endfunction

    // Called at posedge+1; returns at the following posedge+1.
    task automatic send(input int x, input int hand);
        exp_t e;
        if (win.size() == WIN) msum -= longint'(win.pop_front());
        win.push_back(x);
        msum += longint'(x);
        e.val    = (hand == NOHAND) ? spec_avg(msum) : hand;
        e.primed = (win.size() == WIN);
        e.cyc    = cyc;
        sb.push_back(e);
        in_data  = 16'(x);
        in_valid = 1'b1;
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk); #1;
        end
    endtask

    always @(negedge sys_clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stray_out_valid got=%0d want=none (cycle %0d)", out_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", int'(out_data), mon_e.val);
                check("out_primed", int'(out_primed), int'(mon_e.primed));
                check("latency", cyc - mon_e.cyc, 3);
            end
        end
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        reset = 1'b0;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_primed", int'(out_primed), 0);

        // Ramp-up from empty window
        for (int k = 1; k <= WIN; k++) begin
            send(1024, (k == 1) ? 1 : (k == 500) ? 512 : (k == WIN) ? 1024 : NOHAND);
            idle(4);
        end

        // Step to -2000, then hold
        for (int j = 1; j <= WIN + 5; j++) begin
            send(-2000, (j == 1) ? 1021 : (j >= WIN) ? -2000 : NOHAND);
            idle(4);
        end

        // Saturation extremes
        for (int j = 1; j <= WIN; j++) begin
            send(32767, (j == WIN) ? 32767 : NOHAND);
            idle(4);
        end
        for (int j = 1; j <= WIN; j++) begin
            send(-32768, (j == WIN) ? -32768 : NOHAND);
            idle(4);
        end

        // Reset one cycle after a sample enters the pipeline
        send(500, NOHAND);
        reset = 1'b1;
        sb.delete();
        model_flush();
        @(posedge sys_clk); #1;
        reset = 1'b0;
        check("rstmid_out_valid", int'(out_valid), 0);
        check("rstmid_out_data", int'(out_data), 0);
        check("rstmid_out_primed", int'(out_primed), 0);
        idle(6);

        // Back-to-back ramp and step
        for (int k = 1; k <= WIN; k++) begin
            send(1024, (k == 1) ? 1 : (k == 500) ? 512 : (k == WIN) ? 1024 : NOHAND);
        end
        for (int j = 1; j <= WIN; j++) begin
            send(-2000, (j == 1) ? 1021 : (j == WIN) ? -2000 : NOHAND);
        end
        idle(6);

        // Clear while the 600th sample is in flight
        for (int k = 1; k < 600; k++) begin
            send(1000, NOHAND);
            idle(4);
        end
        send(1000, NOHAND);
        clear = 1'b1;
        sb.delete();
        model_flush();
        @(posedge sys_clk); #1;
        clear = 1'b0;
        check("clear_out_valid", int'(out_valid), 0);
        check("clear_out_data", int'(out_data), 0);
        check("clear_out_primed", int'(out_primed), 0);
        idle(4);
        send(1000, 1);
        idle(4);
        send(1000, 2);
        idle(4);

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
